// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M multiply/divide unit, 32-cycle shift-add multiply and restoring divide.
// Divide-by-zero and signed overflow are resolved at accept time and skip straight to FIN.
module muldiv_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [2:0]  FUNC3,
    input  logic [31:0] OP1,
    input  logic [31:0] OP2,
    input  logic        ABORT,
    output logic [31:0] RESULT,
    output logic        BUSY,
    output logic        DONE
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [2:0]  func;
    logic [31:0] opnd;
    logic [63:0] acc, acc_nxt, prod;
    logic        neg_q, neg_r;
    logic        is_mul, s1, s2, n1, n2, div_zero, ovf, special, accept, last, div_ge;
    logic [31:0] m1, m2, spec_res, calc_res, q, r;
    logic [32:0] mul_sum, div_t, div_d;

    assign is_mul   = ~FUNC3[2];
    assign s1       = FUNC3[2] ? ~FUNC3[0] : (FUNC3[1:0] != 2'b11);
    assign s2       = FUNC3[2] ? ~FUNC3[0] : ~FUNC3[1];
    assign n1       = s1 & OP1[31];
    assign n2       = s2 & OP2[31];
    assign m1       = n1 ? -OP1 : OP1;
    assign m2       = n2 ? -OP2 : OP2;
    assign div_zero = FUNC3[2] & (OP2 == 32'd0);
    assign ovf      = FUNC3[2] & ~FUNC3[0] & (OP1 == 32'h8000_0000) & (OP2 == 32'hFFFF_FFFF);
    assign special  = div_zero | ovf;
    assign spec_res = div_zero ? (FUNC3[1] ? OP1 : 32'hFFFF_FFFF) : (FUNC3[1] ? 32'd0 : 32'h8000_0000);
    assign accept   = START & ~ABORT & (state != CALC);
    assign last     = (cnt == 6'd31);

    // Multiply keeps the multiplier in acc[31:0] and accumulates into the top half;
    // divide keeps the partial remainder on top and shifts quotient bits into the bottom.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign div_t    = acc[63:31];
    assign div_d    = div_t - {1'b0, opnd};
    assign div_ge   = div_t >= {1'b0, opnd};
    assign acc_nxt  = ~func[2] ? {mul_sum, acc[31:1]}
                               : {div_ge ? div_d[31:0] : div_t[31:0], acc[30:0], div_ge};
    assign prod     = neg_q ? -acc_nxt : acc_nxt;
    assign q        = acc_nxt[31:0];
    assign r        = acc_nxt[63:32];
    assign calc_res = ~func[2] ? ((func[1:0] == 2'b00) ? prod[31:0] : prod[63:32])
                               : func[1] ? (neg_r ? -r : r) : (neg_q ? -q : q);

    always_comb begin
        state_nxt = state;
        if (ABORT)
            state_nxt = IDLE;
        else if (state == CALC)
            state_nxt = last ? FIN : CALC;
        else
            state_nxt = accept ? (special ? FIN : CALC) : IDLE;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            func   <= 3'd0;
            opnd   <= 32'd0;
            acc    <= 64'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            RESULT <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                func  <= FUNC3;
                opnd  <= is_mul ? m1 : m2;
                acc   <= {32'd0, is_mul ? m2 : m1};
                neg_q <= n1 ^ n2;
                neg_r <= n1;
                cnt   <= 6'd0;
                if (special)
                    RESULT <= spec_res;
            end else if (state == CALC && !ABORT) begin
                acc <= acc_nxt;
                cnt <= cnt + 6'd1;
                if (last)
                    RESULT <= calc_res;
            end
        end
    end

    assign BUSY = (state == CALC);
    assign DONE = (state == FIN);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer with hand-computed results and latencies.
module tb_muldiv_sequencer;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic [2:0]  FUNC3 = 3'd0;
    logic [31:0] OP1 = 32'd0;
    logic [31:0] OP2 = 32'd0;
    logic        ABORT = 1'b0;
    logic [31:0] RESULT;
    logic        BUSY;
    logic        DONE;
    int          vectors = 0;
    int          miscompares = 0;

    muldiv_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNC3(FUNC3), .OP1(OP1), .OP2(OP2),
        .ABORT(ABORT), .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Counts negedges after the accepting edge until DONE, capped at 40.
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        do begin
            @(negedge CLK);
            n++;
            if (BUSY) busy_n++;
        end while (!DONE && n < 40);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n, busy_n;
        @(negedge CLK);
        FUNC3 = f; OP1 = a; OP2 = b; START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0; FUNC3 = ~f; OP1 = $urandom; OP2 = $urandom;
        wait_done(n, busy_n);
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, RESULT, exp);
        check({tag, " busy cycles"}, busy_n, lat - 1);
    endtask

    initial begin
        int n, busy_n, dones;
        logic [31:0] prior;
        #12;
        check("reset RESULT", RESULT, 32'd0);
        check("reset BUSY", {31'd0, BUSY}, 32'd0);
        check("reset DONE", {31'd0, DONE}, 32'd0);
        @(negedge CLK) RESET = 1'b1;

        run_op("MUL 7x-3",        3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("MULHU max",       3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("MULHSU -1x2",     3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("MULH min*min",    3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
        run_op("MUL hex",         3'b000, 32'h1234_5678,  32'h10,        32'h2345_6780, 33);
        run_op("DIV -7/2",        3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33);
        run_op("REM -7/2",        3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33);
        run_op("DIVU 100/7",      3'b101, 32'd100,        32'd7,         32'd14,        33);
        run_op("REMU 100/7",      3'b111, 32'd100,        32'd7,         32'd2,         33);
        run_op("DIV 7/-2",        3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run_op("DIVU 5/0",        3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1);
        run_op("REMU 5/0",        3'b111, 32'd5,          32'd0,         32'd5,         1);
        run_op("REM ovf",         3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);
        run_op("DIV ovf",         3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);

        // Abort at CALC cycle 10: back to IDLE, no DONE, RESULT untouched.
        prior = RESULT;
        @(negedge CLK);
        FUNC3 = 3'b101; OP1 = 32'd100; OP2 = 32'd7; START = 1'b1;
        @(posedge CLK) #1 START = 1'b0;
        repeat (10) @(negedge CLK);
        ABORT = 1'b1;
        @(negedge CLK);
        ABORT = 1'b0;
        check("abort BUSY", {31'd0, BUSY}, 32'd0);
        dones = 0;
        repeat (40) begin @(negedge CLK); if (DONE) dones++; end
        check("abort no DONE", dones, 0);
        check("abort RESULT kept", RESULT, prior);

        // ABORT beats START in the same cycle.
        START = 1'b1; ABORT = 1'b1;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("abort over start BUSY", {31'd0, BUSY}, 32'd0);

        // START during CALC is ignored: one DONE, first operation's result.
        FUNC3 = 3'b000; OP1 = 32'd7; OP2 = 32'hFFFF_FFFD; START = 1'b1;
        @(posedge CLK) #1 START = 1'b0;
        dones = 0; n = 0;
        for (int i = 1; i <= 45; i++) begin
            @(negedge CLK);
            START = (i == 5);
            if (i == 5) begin FUNC3 = 3'b101; OP1 = 32'd100; OP2 = 32'd7; end
            if (DONE) begin dones++; if (n == 0) n = i; end
        end
        check("ignored start DONE count", dones, 1);
        check("ignored start latency", n, 33);
        check("ignored start result", RESULT, 32'hFFFF_FFEB);

        // Back-to-back: START held through FIN picks up the next operands.
        @(negedge CLK);
        FUNC3 = 3'b101; OP1 = 32'd100; OP2 = 32'd7; START = 1'b1;
        @(posedge CLK);
        wait_done(n, busy_n);
        check("b2b first latency", n, 33);
        check("b2b first result", RESULT, 32'd14);
        FUNC3 = 3'b110; OP1 = 32'hFFFF_FFF9; OP2 = 32'd2;
        @(posedge CLK) #1 START = 1'b0;
        wait_done(n, busy_n);
        check("b2b second latency", n, 33);
        check("b2b second result", RESULT, 32'hFFFF_FFFF);

        // Asynchronous reset mid-CALC.
        @(negedge CLK);
        FUNC3 = 3'b000; OP1 = 32'd3; OP2 = 32'd5; START = 1'b1;
        @(posedge CLK) #1 START = 1'b0;
        repeat (10) @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("async reset RESULT", RESULT, 32'd0);
        check("async reset BUSY", {31'd0, BUSY}, 32'd0);
        check("async reset DONE", {31'd0, DONE}, 32'd0);
        @(negedge CLK) RESET = 1'b1;
        dones = 0;
        repeat (40) begin @(negedge CLK); if (DONE) dones++; end
        check("reset discards op", dones, 0);

        // First edge after release accepts START.
        RESET = 1'b0;
        @(negedge CLK);
        RESET = 1'b1; FUNC3 = 3'b101; OP1 = 32'd5; OP2 = 32'd0; START = 1'b1;
        @(posedge CLK) #1 START = 1'b0;
        @(negedge CLK);
        check("post-reset accept DONE", {31'd0, DONE}, 32'd1);
        check("post-reset accept RESULT", RESULT, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous active-low reset; clears state immediately while low, independent of CLK.
REQ-003 SHALL have port START  input  1  request to begin an M-extension operation, sampled on rising CLK.
REQ-004 SHALL have port FUNC3  input  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port OP1  input  32  rs1 operand (multiplicand/dividend).
REQ-006 SHALL have port OP2  input  32  rs2 operand (multiplier/divisor).
REQ-007 SHALL have port ABORT  input  1  pipeline flush; cancels any in-flight operation.
REQ-008 SHALL have port RESULT  output  32  registered result of the last completed operation.
REQ-009 SHALL have port BUSY  output  1  high while an operation is iterating; the pipeline stalls on it.
REQ-010 SHALL have port DONE  output  1  one-cycle pulse; RESULT is valid in the same cycle.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIN; BUSY=1 exactly in CALC; DONE=1 exactly in FIN.
REQ-012 SHALL accept START only in IDLE or FIN (back-to-back); START in CALC SHALL be ignored.
REQ-013 SHALL latch FUNC3, OP1, OP2 at the accepting edge; input changes afterwards SHALL have no effect.
REQ-014 On accept with a normal operation: IDLE/FIN -> CALC, 6-bit iteration counter loaded with 0; CALC SHALL last exactly 32 cycles (counter 0..31), then -> FIN; DONE SHALL therefore be high in the 33rd cycle after the accepting edge.
REQ-015 On accept with a special case (REQ-019, REQ-020) SHALL go directly to FIN; DONE high in the cycle after the accepting edge; BUSY never asserted.
REQ-016 FIN SHALL return to IDLE next edge unless START is high (REQ-012).
REQ-017 Multiply SHALL use unsigned 32-iteration shift-add on operand magnitudes, 64-bit accumulator; signedness: MUL/MULH both signed, MULHSU OP1 signed/OP2 unsigned, MULHU both unsigned; product negated (two's complement, 64-bit) when effective signs differ; MUL returns bits[31:0], others bits[63:32].
REQ-018 Divide SHALL use 32-iteration restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned); quotient negated if operand signs differ; remainder takes sign of dividend; DIV/DIVU return quotient, REM/REMU return remainder.
REQ-019 Divisor zero SHALL give DIV/DIVU = 0xFFFFFFFF and REM/REMU = OP1.
REQ-020 Signed overflow (DIV/REM, OP1=0x80000000, OP2=0xFFFFFFFF) SHALL give DIV = 0x80000000 and REM = 0x00000000.
REQ-021 RESULT SHALL update only on the edge entering FIN and SHALL hold its value otherwise.
REQ-022 ABORT high at an edge SHALL force IDLE, DONE=0, RESULT unchanged; ABORT SHALL take priority over START and over completion in the same cycle.
REQ-023 All outputs SHALL be registered or decoded from state only; no combinational path from inputs to outputs.

Reset
REQ-024 While RESET=0: state IDLE, counter 0, RESULT=0x00000000, BUSY=0, DONE=0, internal operand and accumulator registers 0.
REQ-025 RESET asserted mid-CALC SHALL discard the operation; no DONE SHALL follow after release.
REQ-026 The first edge after RESET release SHALL be able to accept START.

Verification
REQ-027 MUL 7 x -3 (OP2=0xFFFFFFFD) -> BUSY for 32 cycles, DONE in cycle 33, RESULT=0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-028 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-029 DIVU 5/0 -> DONE next cycle, RESULT=0xFFFFFFFF, BUSY stays 0; REM 0x80000000/0xFFFFFFFF -> RESULT=0.
REQ-030 ABORT at CALC cycle 10 -> IDLE next cycle, no DONE pulse, RESULT keeps prior value; START during CALC -> ignored, single DONE.
REQ-031 START held high in FIN with new operands -> second operation accepted, second DONE exactly 33 cycles later.
REQ-032 RESET low mid-CALC -> outputs 0 immediately (asynchronous), no DONE after release; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
